// File: rtl/dsp_st_fifo.sv
// rtl/dsp_st_fifo.sv - elastic Avalon-ST FIFO carrying sop/eop framing, fill and packet counts
module dsp_st_fifo #(
  parameter int DEPTH = 16,
  parameter int ALMOST_FULL_THRESH = DEPTH - 2,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  output logic          sink_ready,
  input  logic [31:0]   sink_data,
  input  logic          sink_valid,
  input  logic          sink_sop,
  input  logic          sink_eop,
  output logic [31:0]   source_data,
  output logic          source_valid,
  output logic          source_sop,
  output logic          source_eop,
  input  logic          source_ready,
  output logic [LW-1:0] fill_level,
  output logic [LW-1:0] pkt_count,
  output logic          almost_full,
  output logic          framing_error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_COUNT = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LEVEL   = LW'(ALMOST_FULL_THRESH);
  localparam logic [LW-1:0] CNT_ONE    = LW'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  // Each entry is {eop, sop, data}
  logic [33:0]   mem [DEPTH];
  logic [33:0]   head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic [LW-1:0] pkts;
  logic          in_pkt;
  logic          ferr;
  logic          push;
  logic          pop;
  logic          push_eop;
  logic          pop_eop;
  logic          bad_sop;
  logic          bad_cont;

  // Handshakes depend only on registered state and clear, so no full-to-empty
  // pass-through path exists and sink_ready never waits on source_ready.
  assign sink_ready   = (count != FULL_COUNT) & ~clear;
  assign source_valid = (count != '0);
  assign push         = sink_valid & sink_ready;
  assign pop          = source_valid & source_ready & ~clear;

  // First-word-fall-through: the head entry is always presented
  assign head         = mem[rd_ptr];
  assign source_data  = head[31:0];
  assign source_sop   = head[32];
  assign source_eop   = head[33];

  assign push_eop     = push & sink_eop;
  assign pop_eop      = pop & head[33];

  // A sop arriving inside a packet, or a continuation word arriving outside one
  assign bad_sop      = push & sink_sop & in_pkt;
  assign bad_cont     = push & ~sink_sop & ~in_pkt;

  assign fill_level    = count;
  assign pkt_count     = pkts;
  assign almost_full   = (count >= AF_LEVEL);
  assign framing_error = ferr;

  // Storage array: written only on an accepted push, contents survive reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {sink_eop, sink_sop, sink_data};
    end
  end

  // Pointers and occupancy; a write slot never aliases the head while it is valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // Complete-packet count: one per stored eop word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkts <= '0;
    end else if (clear) begin
      pkts <= '0;
    end else if (push_eop && !pop_eop) begin
      pkts <= pkts + CNT_ONE;
    end else if (pop_eop && !push_eop) begin
      pkts <= pkts - CNT_ONE;
    end
  end

  // Framing tracker on the write side; the offending word is still stored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pkt <= 1'b0;
      ferr   <= 1'b0;
    end else if (clear) begin
      in_pkt <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      if (push) begin
        if (sink_eop) begin
          in_pkt <= 1'b0;
        end else if (sink_sop) begin
          in_pkt <= 1'b1;
        end
      end
      if (bad_sop || bad_cont) begin
        ferr <= 1'b1;
      end
    end
  end

endmodule

// File: doc/dsp_st_fifo.md
# dsp_st_fifo

Elastic Avalon-ST buffer that sits directly downstream of the DSP block's source port and upstream of the stream-to-memory DMA. It absorbs DMA back-pressure bursts so the FIR/DFT pipelines keep flowing. It stores 32-bit words together with their sop/eop framing, and reports fill level, the number of complete packets held, and a sticky framing-error flag for the CSR block.

## Interface
- DEPTH, 16, number of stored words; power of two, ≥ 4
- ALMOST_FULL_THRESH, DEPTH-2, fill level at which almost_full asserts; 1..DEPTH
- LW = $clog2(DEPTH)+1, derived width of fill_level and pkt_count
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush, from CSR
- sink_ready  out  1  FIFO can accept a word
- sink_data  in  32  word from DSP source
- sink_valid  in  1  word valid
- sink_sop  in  1  first word of packet
- sink_eop  in  1  last word of packet
- source_data  out  32  head-of-FIFO word
- source_valid  out  1  FIFO not empty
- source_sop  out  1  head word sop flag
- source_eop  out  1  head word eop flag
- source_ready  in  1  DMA accepts head word
- fill_level  out  LW  words stored, 0..DEPTH
- pkt_count  out  LW  complete packets (eop stored) currently held
- almost_full  out  1  fill_level ≥ ALMOST_FULL_THRESH
- framing_error  out  1  sticky framing violation

## Operation
- Storage: DEPTH entries of {eop, sop, data[31:0]}. Write pointer and read pointer each wrap modulo DEPTH. A separate count (0..DEPTH) gives the full/empty state.
- Write (push) = sink_valid & sink_ready & !clear.
- Read (pop) = source_valid & source_ready & !clear.
- sink_ready = (count != DEPTH) & !clear. It is combinational from registered state only and never depends on source_ready. When full there is no pass-through, even if a pop occurs in the same cycle.
- source_valid = (count != 0). source_data, source_sop and source_eop show the entry at the read pointer (first-word-fall-through). They are stable while source_valid & !source_ready.
- Count update: push only +1; pop only −1; both together unchanged.
- pkt_count update: +1 on a push carrying eop, −1 on a pop carrying eop, unchanged when both occur in the same cycle.
- Framing tracker: an in_pkt flag sets on a pushed sop and clears on a pushed eop. A word carrying both sop and eop leaves in_pkt at 0.
- framing_error sets when either of these is pushed:
  - a sop word while in_pkt = 1, or
  - a non-sop word while in_pkt = 0.
- The offending word is still stored. framing_error stays set until clear or reset.
- clear resets the pointers, count, pkt_count, in_pkt and framing_error to 0. It takes priority over a simultaneous push or pop; neither transfer occurs in that cycle.
- The memory contents are not reset.

## Timing
- Reset values (rst_n low): source_valid 0, fill_level 0, pkt_count 0, almost_full 0, framing_error 0, sink_ready 1. source_data, source_sop and source_eop are don't-care while source_valid = 0 (memory is not reset). Reset mid-packet discards all stored words and clears in_pkt.
- Latency: a word pushed at edge N is visible with source_valid = 1 after edge N; the minimum latency is 1 cycle.
- Throughput: one push and one pop per cycle sustained, at any count from 1 to DEPTH−1.
- Full (count = DEPTH): sink_ready = 0. It rises the cycle after the first pop.
- Empty: source_valid = 0. A simultaneous push does not bypass to the source in the same cycle.
- fill_level, pkt_count, almost_full and framing_error are registered-state outputs. They update on the same edge as the transfer that changes them.
- Pointer wrap: the entry at index DEPTH−1 is followed by index 0 with no bubble.

## Test plan
- Reset, push one packet of 3 words (sop on A0, eop on A2) with source_ready = 0:
  - fill_level = 3, pkt_count = 1, source_data = A0, source_sop = 1.
  - Then source_ready = 1: A0, A1, A2 drain on 3 consecutive cycles, with eop on A2 only, and counts return to 0.
- DEPTH = 16, source_ready = 0, push 20 words:
  - Exactly 16 are accepted and sink_ready = 0 after the 16th.
  - almost_full asserts when fill_level reaches 14.
  - One pop re-raises sink_ready on the next cycle.
- Continuous push and pop for 40 words with count held at 5:
  - Data order is preserved across the pointer wrap and fill_level stays at 5 every cycle.
- Push the sequence sop, data, sop (missing eop):
  - framing_error = 1 after the second sop and stays set.
  - All 3 words are still stored.
  - Asserting clear for one cycle sets fill_level = 0, framing_error = 0 and source_valid = 0.
- Single-word packet (sop = eop = 1) pushed in the same cycle as a pop of a stored eop word:
  - pkt_count is unchanged, no framing_error, and fill_level is unchanged.
- Assert rst_n low mid-packet with 7 words stored:
  - All outputs immediately return to their reset values, with no clock edge required.
  - After release, a fresh sop-first packet does not raise framing_error.
